// File: rtl/addr8u_mon_pkg.sv
// rtl/addr8u_mon_pkg.sv - shared widths, pipeline state and golden adder model for addr8u_sum_monitor
package addr8u_mon_pkg;

  localparam int SUM_W = 9;
  localparam int OPD_W = 8;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } mon_state_t;

  function automatic logic [SUM_W-1:0] golden_sum(input logic [OPD_W-1:0] a,
                                                  input logic [OPD_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/addr8u_mon_stats.sv
// rtl/addr8u_mon_stats.sv - vector/error counters, sticky error mask and first-error snapshot
module addr8u_mon_stats
  import addr8u_mon_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             accept,
  input  logic             mis,
  input  logic [SUM_W-1:0] diff,
  input  logic [OPD_W-1:0] in_a,
  input  logic [OPD_W-1:0] in_b,
  input  logic [SUM_W-1:0] in_sum,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] err_mask,
  output logic             first_vld,
  output logic [OPD_W-1:0] first_a,
  output logic [OPD_W-1:0] first_b,
  output logic [SUM_W-1:0] first_sum
);

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_cnt   <= '0;
      err_cnt   <= '0;
      err_mask  <= '0;
      first_vld <= 1'b0;
      first_a   <= '0;
      first_b   <= '0;
      first_sum <= '0;
    end else if (clr) begin
      // The snapshot payload stays; only its valid flag is dropped.
      vec_cnt   <= '0;
      err_cnt   <= '0;
      err_mask  <= '0;
      first_vld <= 1'b0;
    end else if (accept) begin
      vec_cnt  <= vec_cnt + 1'b1;
      err_mask <= err_mask | diff;
      if (mis && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + 1'b1;
      end
      if (mis && !first_vld) begin
        first_vld <= 1'b1;
        first_a   <= in_a;
        first_b   <= in_b;
        first_sum <= in_sum;
      end
    end
  end

endmodule

// File: rtl/addr8u_sum_monitor.sv
// rtl/addr8u_sum_monitor.sv - checking stage for addr8u adders with one-entry valid/ready register
// Optional: ADDR8U_MON_CORRECT_EN forwards the golden sum on mismatch.
module addr8u_sum_monitor
  import addr8u_mon_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPD_W-1:0] in_a,
  input  logic [OPD_W-1:0] in_b,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_err,
  input  logic             clr,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] err_mask,
  output logic             first_vld,
  output logic [OPD_W-1:0] first_a,
  output logic [OPD_W-1:0] first_b,
  output logic [SUM_W-1:0] first_sum
);

  mon_state_t       state;
  logic [SUM_W-1:0] golden;
  logic [SUM_W-1:0] diff;
  logic             mis;
  logic             accept;
  logic [SUM_W-1:0] fwd_sum;

  assign golden   = golden_sum(in_a, in_b);
  assign diff     = in_sum ^ golden;
  assign mis      = |diff;
  assign in_ready = (state == ST_EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef ADDR8U_MON_CORRECT_EN
  assign fwd_sum = mis ? golden : in_sum;
`else
  assign fwd_sum = in_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_err   <= 1'b0;
    end else if (state == ST_EMPTY) begin
      if (accept) begin
        state     <= ST_FULL;
        out_valid <= 1'b1;
        out_sum   <= fwd_sum;
        out_err   <= mis;
      end
    end else if (out_ready) begin
      if (in_valid) begin
        out_sum <= fwd_sum;
        out_err <= mis;
      end else begin
        state     <= ST_EMPTY;
        out_valid <= 1'b0;
      end
    end
  end

  addr8u_mon_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .accept   (accept),
    .mis      (mis),
    .diff     (diff),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sum   (in_sum),
    .vec_cnt  (vec_cnt),
    .err_cnt  (err_cnt),
    .err_mask (err_mask),
    .first_vld(first_vld),
    .first_a  (first_a),
    .first_b  (first_b),
    .first_sum(first_sum)
  );

endmodule
